// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
//   Bundles every non-clock/reset signal of alu_share_ctrl: the two request
//   ports, the ALU operand/result bus, the response channel, flush and busy.
//   slave  : the sequencer/arbiter side (alu_share_ctrl itself).
//   master : the surrounding pipeline + ALU side (issue logic, consumer, ALU).
interface alu_share_ctrl_if #(
  parameter int TAG_W = 4
);
  // request port 0 (integer EX stage)
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  // request port 1 (FP/convert issue path)
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  // shared ALU
  logic [4:0]       alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             alu_set;
  logic             alu_overflow;
  logic             alu_carryout;
  // response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  // control / status
  logic             flush;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  alu_result, alu_zero, alu_set, alu_overflow, alu_carryout,
    input  rsp_ready, flush,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_flags, rsp_src, rsp_tag,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output alu_result, alu_zero, alu_set, alu_overflow, alu_carryout,
    output rsp_ready, flush,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_flags, rsp_src, rsp_tag,
    input  busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one combinational ALU between two requesters (port 0 = integer EX,
//   port 1 = FP/convert issue). Round-robin arbitration, operands registered
//   and held for the op latency, result/flags captured and returned through a
//   valid/ready response.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_share_ctrl_if.slave (requests, ALU bus, response, flush, busy)
module alu_share_ctrl #(
  parameter int TAG_W   = 4,
  parameter int FP_LAT  = 3,
  parameter int INT_LAT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_share_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ADDF and CVTI2F are the only multi-cycle codes; 5'b11111 stays INT.
  function automatic logic is_fp(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b11110);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_src_q, rsp_src_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;

  logic             can_accept_s;
  logic             accept_s;
  logic             grant_s;
  logic [4:0]       sel_op_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic [3:0]       sel_lat_s;

  // A new op may start from IDLE, or from DONE in the same cycle the response drains.
  assign can_accept_s = !bus.flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.rsp_ready));
  assign accept_s     = can_accept_s && (bus.req0_valid || bus.req1_valid);

  // Round-robin: on contention the port that did not win last time is granted.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign bus.req0_ready = accept_s && !grant_s;
  assign bus.req1_ready = accept_s && grant_s;

  assign sel_op_s  = grant_s ? bus.req1_op  : bus.req0_op;
  assign sel_a_s   = grant_s ? bus.req1_a   : bus.req0_a;
  assign sel_b_s   = grant_s ? bus.req1_b   : bus.req0_b;
  assign sel_tag_s = grant_s ? bus.req1_tag : bus.req0_tag;
  // Counter holds remaining EXEC cycles minus one; latency 1 loads 0.
  assign sel_lat_s = is_fp(sel_op_s) ? 4'(FP_LAT - 1) : 4'(INT_LAT - 1);

  // Next-state logic for the sequencer, operand holding and response capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_src_d    = rsp_src_q;
    rsp_tag_d    = rsp_tag_q;
    // Operands only change on an accept, so they stay frozen through EXEC and flush.
    alu_op_d     = accept_s ? sel_op_s  : alu_op_q;
    alu_a_d      = accept_s ? sel_a_s   : alu_a_q;
    alu_b_d      = accept_s ? sel_b_s   : alu_b_q;
    tag_d        = accept_s ? sel_tag_s : tag_q;
    src_d        = accept_s ? grant_s   : src_q;
    last_grant_d = accept_s ? grant_s   : last_grant_q;
    if (bus.flush) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = ST_EXEC;
            cnt_d   = sel_lat_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            state_d      = ST_DONE;
            rsp_valid_d  = 1'b1;
            rsp_result_d = bus.alu_result;
            rsp_flags_d  = {bus.alu_carryout, bus.alu_overflow, bus.alu_set, bus.alu_zero};
            rsp_src_d    = src_q;
            rsp_tag_d    = tag_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            if (accept_s) begin
              state_d = ST_EXEC;
              cnt_d   = sel_lat_s;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      alu_op_q     <= 5'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= '0;
      tag_q        <= '0;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_src_q    <= rsp_src_d;
      rsp_tag_q    <= rsp_tag_d;
      tag_q        <= tag_d;
      src_q        <= src_d;
    end
  end

  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  alu_share_ctrl_if #(.TAG_W(4)) bus ();

  alu_share_ctrl #(.TAG_W(4), .FP_LAT(3), .INT_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Simple ALU stand-in: ADD/ADDF add, SUB, AND, CVTI2F passes A through.
  always_comb begin
    logic [32:0] sum;
    sum              = 33'd0;
    bus.alu_result   = 32'd0;
    bus.alu_carryout = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.alu_set      = 1'b0;
    case (bus.alu_op)
      5'b00010, 5'b01111: begin
        sum              = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result   = sum[31:0];
        bus.alu_carryout = sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      5'b00110: bus.alu_result = bus.alu_a - bus.alu_b;
      5'b00000: bus.alu_result = bus.alu_a & bus.alu_b;
      5'b11110: bus.alu_result = bus.alu_a;
      default:  bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set0(input logic v, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
  endtask

  task automatic set1(input logic v, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    errors = 0;
    checks = 0;
    set0(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    bus.rsp_ready = 1'b0;
    bus.flush = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_op", bus.alu_op, 5'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_flags", bus.rsp_flags, 4'd0);
    chk("rst_rsp_tag", bus.rsp_tag, 4'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single INT op on port 0: 5+7
    bus.rsp_ready = 1'b1;
    set0(1'b1, 5'b00010, 32'd5, 32'd7, 4'd3);
    #1;
    chk("int_req0_ready", bus.req0_ready, 1'b1);
    chk("int_req1_ready", bus.req1_ready, 1'b0);
    tick();
    set0(1'b0, 5'b00010, 32'd5, 32'd7, 4'd3);
    chk("int_busy", bus.busy, 1'b1);
    chk("int_alu_op", bus.alu_op, 5'b00010);
    chk("int_alu_a", bus.alu_a, 32'd5);
    chk("int_alu_b", bus.alu_b, 32'd7);
    chk("int_no_rsp_yet", bus.rsp_valid, 1'b0);
    tick();
    chk("int_rsp_valid", bus.rsp_valid, 1'b1);
    chk("int_result", bus.rsp_result, 32'd12);
    chk("int_flags", bus.rsp_flags, 4'b0000);
    chk("int_src", bus.rsp_src, 1'b0);
    chk("int_tag", bus.rsp_tag, 4'd3);
    tick();
    chk("int_idle_valid", bus.rsp_valid, 1'b0);
    chk("int_idle_busy", bus.busy, 1'b0);

    // FP latency on port 1: ADDF 10+20, response three cycles after accept
    set1(1'b1, 5'b01111, 32'd10, 32'd20, 4'd9);
    #1;
    chk("fp_req1_ready", bus.req1_ready, 1'b1);
    tick();
    set1(1'b0, 5'b01111, 32'd10, 32'd20, 4'd9);
    for (int i = 0; i < 3; i++) begin
      chk("fp_no_rsp", bus.rsp_valid, 1'b0);
      chk("fp_alu_op_hold", bus.alu_op, 5'b01111);
      chk("fp_alu_a_hold", bus.alu_a, 32'd10);
      chk("fp_alu_b_hold", bus.alu_b, 32'd20);
      tick();
    end
    chk("fp_rsp_valid", bus.rsp_valid, 1'b1);
    chk("fp_result", bus.rsp_result, 32'd30);
    chk("fp_src", bus.rsp_src, 1'b1);
    chk("fp_tag", bus.rsp_tag, 4'd9);
    tick();
    chk("fp_idle_busy", bus.busy, 1'b0);

    // Contention: both ports valid, grants alternate 0,1,0 two cycles apart
    set0(1'b1, 5'b00010, 32'd1, 32'd1, 4'd1);
    set1(1'b1, 5'b00010, 32'd2, 32'd2, 4'd2);
    #1;
    chk("rr_first_req0", bus.req0_ready, 1'b1);
    chk("rr_first_req1", bus.req1_ready, 1'b0);
    tick();
    chk("rr_exec_req0", bus.req0_ready, 1'b0);
    chk("rr_exec_req1", bus.req1_ready, 1'b0);
    tick();
    chk("rr_r1_result", bus.rsp_result, 32'd2);
    chk("rr_r1_tag", bus.rsp_tag, 4'd1);
    chk("rr_r1_src", bus.rsp_src, 1'b0);
    chk("rr_second_req1", bus.req1_ready, 1'b1);
    chk("rr_second_req0", bus.req0_ready, 1'b0);
    tick();
    chk("rr_drop_valid", bus.rsp_valid, 1'b0);
    tick();
    chk("rr_r2_valid", bus.rsp_valid, 1'b1);
    chk("rr_r2_result", bus.rsp_result, 32'd4);
    chk("rr_r2_tag", bus.rsp_tag, 4'd2);
    chk("rr_r2_src", bus.rsp_src, 1'b1);
    chk("rr_third_req0", bus.req0_ready, 1'b1);
    tick();
    set0(1'b0, 5'b00010, 32'd1, 32'd1, 4'd1);
    set1(1'b0, 5'b00010, 32'd2, 32'd2, 4'd2);
    tick();
    chk("rr_r3_tag", bus.rsp_tag, 4'd1);
    chk("rr_r3_src", bus.rsp_src, 1'b0);
    tick();

    // Backpressure: SUB 5-5 (zero flag) held four cycles, then same-cycle reissue
    bus.rsp_ready = 1'b0;
    set0(1'b1, 5'b00110, 32'd5, 32'd5, 4'd4);
    tick();
    set0(1'b0, 5'b00110, 32'd5, 32'd5, 4'd4);
    tick();
    set0(1'b1, 5'b00010, 32'hFFFF_FFFF, 32'd1, 4'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_result", bus.rsp_result, 32'd0);
      chk("bp_flags", bus.rsp_flags, 4'b0001);
      chk("bp_tag", bus.rsp_tag, 4'd4);
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_reissue_ready", bus.req0_ready, 1'b1);
    tick();
    set0(1'b0, 5'b00010, 32'hFFFF_FFFF, 32'd1, 4'd5);
    chk("bp_valid_drop", bus.rsp_valid, 1'b0);
    chk("bp_alu_a_new", bus.alu_a, 32'hFFFF_FFFF);
    tick();
    chk("bp_r2_valid", bus.rsp_valid, 1'b1);
    chk("bp_r2_result", bus.rsp_result, 32'd0);
    chk("bp_r2_flags", bus.rsp_flags, 4'b1001);
    chk("bp_r2_tag", bus.rsp_tag, 4'd5);
    tick();

    // Flush during FP EXEC (CVTI2F on port 1)
    set1(1'b1, 5'b11110, 32'd7, 32'd0, 4'd6);
    tick();
    set1(1'b0, 5'b11110, 32'd7, 32'd0, 4'd6);
    tick();
    bus.flush = 1'b1;
    set0(1'b1, 5'b00010, 32'd3, 32'd4, 4'd7);
    #1;
    chk("fl_no_accept", bus.req0_ready, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk("fl_idle_busy", bus.busy, 1'b0);
    chk("fl_no_rsp", bus.rsp_valid, 1'b0);
    chk("fl_alu_op_kept", bus.alu_op, 5'b11110);
    chk("fl_alu_a_kept", bus.alu_a, 32'd7);
    #1;
    chk("fl_next_ready", bus.req0_ready, 1'b1);
    tick();
    set0(1'b0, 5'b00010, 32'd3, 32'd4, 4'd7);
    chk("fl_next_busy", bus.busy, 1'b1);
    chk("fl_next_alu_op", bus.alu_op, 5'b00010);
    chk("fl_next_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    chk("fl_next_result", bus.rsp_result, 32'd7);
    chk("fl_next_tag", bus.rsp_tag, 4'd7);
    tick();

    // Async reset mid-DONE, then port 0 wins the first contended arbitration
    bus.rsp_ready = 1'b0;
    set1(1'b1, 5'b00000, 32'hF0, 32'hFF, 4'd8);
    tick();
    set1(1'b0, 5'b00000, 32'hF0, 32'hFF, 4'd8);
    tick();
    chk("ar_done_valid", bus.rsp_valid, 1'b1);
    chk("ar_done_result", bus.rsp_result, 32'hF0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid_drop", bus.rsp_valid, 1'b0);
    chk("ar_busy_drop", bus.busy, 1'b0);
    tick();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set0(1'b1, 5'b00010, 32'd11, 32'd1, 4'd10);
    set1(1'b1, 5'b00010, 32'd22, 32'd2, 4'd11);
    #1;
    chk("ar_first_req0", bus.req0_ready, 1'b1);
    chk("ar_first_req1", bus.req1_ready, 1'b0);
    tick();
    set0(1'b0, 5'b00010, 32'd11, 32'd1, 4'd10);
    set1(1'b0, 5'b00010, 32'd22, 32'd2, 4'd11);
    chk("ar_alu_a", bus.alu_a, 32'd11);
    tick();
    chk("ar_rsp_result", bus.rsp_result, 32'd12);
    chk("ar_rsp_src", bus.rsp_src, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational ALU (Op[4:0], 32-bit A/B, Result/Zero/Set/Overflow/Carryout) between two requesters: port 0 is the integer EX stage, port 1 is the FP/convert issue path.
- Registers operands, holds the ALU inputs stable for the op's latency, captures the result and flags, and returns them with a valid/ready response handshake.
- Multi-cycle FP ops (ADDF, CVTI2F) are given extra settle cycles.
- Sits between the pipeline issue logic and the ALU instance.

Parameters:
- TAG_W, 4, width of the requester tag echoed on the response.
- FP_LAT, 3, execute cycles for FP ops; legal range 1..15.
- INT_LAT, 1, execute cycles for all other ops; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight op and any pending response.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 accepted this cycle.
- req0_op  in  5  ALU op code.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- req0_tag  in  TAG_W  requester tag.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as port 0, for port 1.
- alu_op  out  5  registered Op to the ALU.
- alu_a  out  32  registered A to the ALU.
- alu_b  out  32  registered B to the ALU.
- alu_result  in  32  ALU Result.
- alu_zero  in  1  ALU Zero.
- alu_set  in  1  ALU Set.
- alu_overflow  in  1  ALU Overflow.
- alu_carryout  in  1  ALU Carryout.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_flags  out  4  captured flags {carryout, overflow, set, zero}.
- rsp_src  out  1  port that issued the op.
- rsp_tag  out  TAG_W  echoed tag.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (reset_n low, async) clears everything:
  - State = IDLE.
  - alu_op/alu_a/alu_b = 0.
  - rsp_valid = 0; rsp_result, rsp_flags, rsp_tag, rsp_src = 0.
  - last_grant = 1, so port 0 wins first.
  - Execute counter = 0.
  - busy = 0.
- Op classes:
  - FP = op 5'b01111 (ADDF) or 5'b11110 (CVTI2F); latency FP_LAT.
  - Every other code, including 5'b11111, is INT; latency INT_LAT.
- can_accept = (state==IDLE) | (state==DONE & rsp_ready), and flush low.
- Arbitration (round-robin, two ports):
  - One valid port: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - reqN_ready = can_accept & granted(N); this is combinational.
  - last_grant updates only on an accept.
- States:
  - IDLE: on accept, load alu_op/alu_a/alu_b, tag and src; counter = latency-1; go to EXEC.
  - EXEC: counter decrements each cycle. When counter==0, at the edge, capture alu_result and the flags into rsp_*, set rsp_valid=1, go to DONE. alu_* inputs are held constant for the whole of EXEC.
  - DONE: rsp_valid held with stable data until rsp_ready.
    - rsp_ready with no new accept → IDLE, rsp_valid=0.
    - rsp_ready with a same-cycle accept → EXEC with the new operands; rsp_valid drops.
- Timing:
  - Accept at edge t → rsp_valid high after edge t+L, where L = class latency.
  - Minimum issue interval is L+1 cycles (back-to-back issue through DONE).
- flush:
  - Any state → IDLE, rsp_valid=0.
  - No accept in the flush cycle (ready=0).
  - alu_* keep their last values.
  - last_grant is unchanged.
- Reset mid-EXEC or mid-DONE: the op is discarded with no response.
- A latency of 1 for INT_LAT or FP_LAT is legal; the counter is loaded with 0.
- rsp_flags bit order is fixed: [3]=carryout, [2]=overflow, [1]=set, [0]=zero.

Test Plan:
- Single INT op: port0 op=00010, A=5, B=7, tag=3, rsp_ready=1 → rsp_valid 1 cycle after accept; result=12, flags=0000, src=0, tag=3; then back to IDLE.
- FP latency: port1 op=01111 with FP_LAT=3 → alu_* stable for 3 cycles; rsp_valid exactly 3 cycles after accept; src=1.
- Contention: both ports valid continuously with INT ops and rsp_ready=1 → grants alternate 0,1,0,1; each accept is 2 cycles apart; responses carry the correct tags.
- Backpressure: rsp_ready=0 for 4 cycles in DONE → rsp_* unchanged, req ready=0. Then rsp_ready=1 with port0 valid → same-cycle accept; next response follows.
- Flush: assert flush during FP EXEC → no rsp_valid, state IDLE next cycle, next request accepted the following cycle.
- Async reset: pull reset_n low mid-DONE without a clock edge → rsp_valid and busy drop immediately. After release, port 0 wins the first contended arbitration.
